// File: rtl/input_conditioner.sv
// Switch/hold-button front end: 2-flop synchronisers, per-channel counting
// debouncers, and a hold-button press detector that toggles the retain level.
module input_conditioner #(
  parameter int N               = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] switches_raw,
  input  logic         hold_btn_raw,
  output logic [N-1:0] switches_clean,
  output logic         retain,
  output logic         hold_pressed
);

  // Channel N is the hold button; channels 0..N-1 are the switches.
  localparam int CH = N + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CH-1:0] sync_p0;
  logic [CH-1:0] sync_p1;
  logic [CH-1:0] stable_p2;
  logic          btn_prev;
  logic          btn_rise;

  // Stage p0/p1: two-flop synchroniser, the only path from the raw pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {hold_btn_raw, switches_raw};
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: a level is accepted only after DEBOUNCE_CYCLES straight mismatches.
  for (genvar i = 0; i < CH; i++) begin : g_debounce
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt          <= '0;
        stable_p2[i] <= 1'b0;
      end else if (sync_p1[i] == stable_p2[i]) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt          <= '0;
        stable_p2[i] <= sync_p1[i];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign btn_rise = stable_p2[N] & ~btn_prev;

  // Stage p3: press detection; only the debounced rising edge toggles retain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_prev     <= 1'b0;
      hold_pressed <= 1'b0;
      retain       <= 1'b0;
    end else begin
      btn_prev     <= stable_p2[N];
      hold_pressed <= btn_rise;
      if (btn_rise) retain <= ~retain;
    end
  end

  assign switches_clean = stable_p2[N-1:0];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES = 4, N = 8.
module tb_input_conditioner;

  localparam int N  = 8;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] switches_raw;
  logic         hold_btn_raw;
  logic [N-1:0] switches_clean;
  logic         retain;
  logic         hold_pressed;

  int checks = 0;
  int fails  = 0;

  input_conditioner #(.N(N), .DEBOUNCE_CYCLES(DB)) dut (
    .clk           (clk),
    .reset         (reset),
    .switches_raw  (switches_raw),
    .hold_btn_raw  (hold_btn_raw),
    .switches_clean(switches_clean),
    .retain        (retain),
    .hold_pressed  (hold_pressed)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs set here are sampled on the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    switches_raw = 8'hFF;
    hold_btn_raw = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      checks++;
      if ({switches_clean, retain, hold_pressed} !== 10'b0) begin
        fails++;
        $display("FAIL reset_outputs cycle %0d: got sw=%h ret=%b hp=%b, want all 0",
                 k, switches_clean, retain, hold_pressed);
      end
    end
    step();
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      logic [N-1:0] exp_sw;
      step();
      exp_sw = (k >= 6) ? 8'hFF : 8'h00;
      checks++;
      if (switches_clean !== exp_sw) begin
        fails++;
        $display("FAIL reset_release edge %0d: got %h want %h", k, switches_clean, exp_sw);
      end
    end
  endtask

  task automatic test_short_bounce();
    switches_raw = 8'h00;
    repeat (10) step();
    checks++;
    if (switches_clean !== 8'h00) begin
      fails++;
      $display("FAIL settle_zero: got %h want 00", switches_clean);
    end
    switches_raw = 8'h08;
    repeat (3) step();
    switches_raw = 8'h00;
    for (int k = 0; k < 12; k++) begin
      step();
      checks++;
      if (switches_clean !== 8'h00 || hold_pressed !== 1'b0) begin
        fails++;
        $display("FAIL short_bounce cycle %0d: got sw=%h hp=%b want sw=00 hp=0",
                 k, switches_clean, hold_pressed);
      end
    end
  endtask

  task automatic test_bounce_burst();
    int           trans;
    logic [N-1:0] prev;
    trans = 0;
    prev  = switches_clean;
    for (int ph = 0; ph < 2; ph++) begin
      switches_raw = (ph == 0) ? 8'hA5 : 8'h00;
      repeat (2) begin
        step();
        if (switches_clean !== prev) trans++;
        prev = switches_clean;
        checks++;
        if (switches_clean !== 8'h00) begin
          fails++;
          $display("FAIL burst_hold phase %0d: got %h want 00", ph, switches_clean);
        end
      end
    end
    switches_raw = 8'hA5;
    for (int k = 1; k <= 10; k++) begin
      logic [N-1:0] exp_sw;
      step();
      if (switches_clean !== prev) trans++;
      prev   = switches_clean;
      exp_sw = (k >= 6) ? 8'hA5 : 8'h00;
      checks++;
      if (switches_clean !== exp_sw) begin
        fails++;
        $display("FAIL burst_settle edge %0d: got %h want %h", k, switches_clean, exp_sw);
      end
    end
    checks++;
    if (trans !== 1) begin
      fails++;
      $display("FAIL burst_transitions: got %0d want 1", trans);
    end
  endtask

  // Drive the button to a level for 20 cycles and check pulse position and retain.
  task automatic button_phase(input logic level, input logic ret_before, input string name);
    int pulses;
    pulses       = 0;
    hold_btn_raw = level;
    for (int k = 1; k <= 20; k++) begin
      logic exp_hp;
      logic exp_ret;
      step();
      exp_hp  = level && (k == 7);
      exp_ret = (level && k >= 7) ? ~ret_before : ret_before;
      if (hold_pressed === 1'b1) pulses++;
      checks++;
      if (hold_pressed !== exp_hp || retain !== exp_ret) begin
        fails++;
        $display("FAIL %s edge %0d: got hp=%b ret=%b want hp=%b ret=%b",
                 name, k, hold_pressed, retain, exp_hp, exp_ret);
      end
    end
    checks++;
    if (pulses !== (level ? 1 : 0)) begin
      fails++;
      $display("FAIL %s_pulse_count: got %0d want %0d", name, pulses, level ? 1 : 0);
    end
  endtask

  task automatic test_hold_toggle();
    button_phase(1'b1, 1'b0, "press1");
    button_phase(1'b0, 1'b1, "release1");
    button_phase(1'b1, 1'b1, "press2");
    button_phase(1'b0, 1'b0, "release2");
  endtask

  task automatic test_reset_while_held();
    button_phase(1'b1, 1'b0, "prehold");
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (k > 0) step();
      checks++;
      if ({switches_clean, retain, hold_pressed} !== 10'b0) begin
        fails++;
        $display("FAIL held_reset cycle %0d: got sw=%h ret=%b hp=%b want all 0",
                 k, switches_clean, retain, hold_pressed);
      end
    end
    step();
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      logic exp_hp;
      logic exp_ret;
      logic [N-1:0] exp_sw;
      step();
      exp_hp  = (k == 7);
      exp_ret = (k >= 7);
      exp_sw  = (k >= 6) ? 8'hA5 : 8'h00;
      checks++;
      if (hold_pressed !== exp_hp || retain !== exp_ret || switches_clean !== exp_sw) begin
        fails++;
        $display("FAIL held_release edge %0d: got hp=%b ret=%b sw=%h want hp=%b ret=%b sw=%h",
                 k, hold_pressed, retain, switches_clean, exp_hp, exp_ret, exp_sw);
      end
    end
  endtask

  task automatic test_simultaneous();
    hold_btn_raw = 1'b0;
    switches_raw = 8'h00;
    repeat (12) step();
    checks++;
    if (switches_clean !== 8'h00 || retain !== 1'b1 || hold_pressed !== 1'b0) begin
      fails++;
      $display("FAIL simul_baseline: got sw=%h ret=%b hp=%b want sw=00 ret=1 hp=0",
               switches_clean, retain, hold_pressed);
    end
    switches_raw = 8'h3C;
    hold_btn_raw = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      logic exp_hp;
      logic exp_ret;
      logic [N-1:0] exp_sw;
      step();
      exp_sw  = (k >= 6) ? 8'h3C : 8'h00;
      exp_hp  = (k == 7);
      exp_ret = (k >= 7) ? 1'b0 : 1'b1;
      checks++;
      if (switches_clean !== exp_sw || hold_pressed !== exp_hp || retain !== exp_ret) begin
        fails++;
        $display("FAIL simultaneous edge %0d: got sw=%h hp=%b ret=%b want sw=%h hp=%b ret=%b",
                 k, switches_clean, hold_pressed, retain, exp_sw, exp_hp, exp_ret);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_bounce();
    test_bounce_burst();
    test_hold_toggle();
    test_reset_while_held();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
